// File: rtl/branch_predict_ctrl_if.sv
// rtl/branch_predict_ctrl_if.sv - IF predict / EX resolve / redirect bundle for the branch controller
interface branch_predict_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             if_valid;
    logic             if_is_branch;
    logic [31:0]      if_pc;
    logic [31:0]      if_target;
    logic             pred_taken;
    logic [31:0]      pred_pc;
    logic             ex_valid;
    logic             ex_is_branch;
    logic             ex_jump;
    logic [31:0]      ex_pc;
    logic [31:0]      ex_target;
    logic             ex_pred_taken;
    logic             ex_branch;
    logic             redirect;
    logic [31:0]      redirect_pc;
    logic             flush;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] mispred_count;

    modport master (
        output if_valid, if_is_branch, if_pc, if_target,
        output ex_valid, ex_is_branch, ex_jump, ex_pc, ex_target, ex_pred_taken, ex_branch,
        input  pred_taken, pred_pc, redirect, redirect_pc, flush, br_count, mispred_count
    );

    modport slave (
        input  if_valid, if_is_branch, if_pc, if_target,
        input  ex_valid, ex_is_branch, ex_jump, ex_pc, ex_target, ex_pred_taken, ex_branch,
        output pred_taken, pred_pc, redirect, redirect_pc, flush, br_count, mispred_count
    );
endinterface

// File: rtl/branch_predict_ctrl.sv
// rtl/branch_predict_ctrl.sv - 2-bit BHT branch predictor with EX-stage resolve, redirect and timed flush
module branch_predict_ctrl #(
    parameter int IDX_W     = 4,
    parameter int FLUSH_CYC = 2,
    parameter int CNT_W     = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    branch_predict_ctrl_if.slave bp
);
    localparam int NENT = 1 << IDX_W;
    localparam int FC_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t           state;
    logic [FC_W-1:0]  cnt;
    logic [1:0]       bht [NENT];
    logic             redirect_r;
    logic [31:0]      redirect_pc_r;
    logic             flush_r;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] mis_cnt;

    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;
    logic [1:0]       if_ctr;
    logic [1:0]       ex_ctr;
    logic             pred;
    logic             res;
    logic             mis;

    assign if_idx = bp.if_pc[IDX_W+1:2];
    assign ex_idx = bp.ex_pc[IDX_W+1:2];
    assign if_ctr = bht[if_idx];
    assign ex_ctr = bht[ex_idx];

    // Reads the pre-edge table, so a same-cycle train of this entry is not yet visible
    assign pred          = bp.if_valid & bp.if_is_branch & if_ctr[1];
    assign bp.pred_taken = pred;
    assign bp.pred_pc    = pred ? bp.if_target : bp.if_pc + 32'd4;

    assign res = bp.ex_valid & bp.ex_is_branch & (state == IDLE);
    assign mis = res & (bp.ex_branch != bp.ex_pred_taken);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NENT; i++) bht[i] <= 2'b01;
            state         <= IDLE;
            cnt           <= '0;
            redirect_r    <= 1'b0;
            redirect_pc_r <= 32'd0;
            flush_r       <= 1'b0;
            br_cnt        <= '0;
            mis_cnt       <= '0;
        end else begin
            redirect_r <= 1'b0;
            if (res) begin
                br_cnt <= br_cnt + CNT_W'(1);
                if (!bp.ex_jump) begin
                    if (bp.ex_branch) begin
                        if (ex_ctr != 2'b11) bht[ex_idx] <= ex_ctr + 2'd1;
                    end else begin
                        if (ex_ctr != 2'b00) bht[ex_idx] <= ex_ctr - 2'd1;
                    end
                end
            end
            case (state)
                IDLE: begin
                    if (mis) begin
                        state         <= FLUSH;
                        redirect_r    <= 1'b1;
                        redirect_pc_r <= bp.ex_branch ? bp.ex_target : bp.ex_pc + 32'd4;
                        flush_r       <= 1'b1;
                        mis_cnt       <= mis_cnt + CNT_W'(1);
                        cnt           <= FC_W'(FLUSH_CYC - 1);
                    end
                end
                FLUSH: begin
                    if (cnt == '0) begin
                        state   <= IDLE;
                        flush_r <= 1'b0;
                    end else begin
                        cnt <= cnt - FC_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bp.redirect      = redirect_r;
    assign bp.redirect_pc   = redirect_pc_r;
    assign bp.flush         = flush_r;
    assign bp.br_count      = br_cnt;
    assign bp.mispred_count = mis_cnt;
endmodule

// File: tb/tb_branch_predict_ctrl.sv
// tb/tb_branch_predict_ctrl.sv - vector table, corner sequences and randomized model check for branch_predict_ctrl
module tb_branch_predict_ctrl;
    localparam int FLUSH_CYC = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    branch_predict_ctrl_if #(.CNT_W(16)) bpi ();

    branch_predict_ctrl #(.IDX_W(4), .FLUSH_CYC(FLUSH_CYC), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bp    (bpi)
    );

    typedef struct {
        logic        ifv, ifb;
        logic [31:0] ifpc, iftg;
        logic        exv, exb, exj;
        logic [31:0] expc, extg;
        logic        expt, exbr;
        logic        e_pred;
        logic [31:0] e_ppc;
        logic        e_red;
        logic [31:0] e_rpc;
        logic        e_flush;
        logic [15:0] e_mc, e_brc;
    } vec_t;

    vec_t vt[$];

    // reference model state
    int          m_bht [16];
    int          m_brc, m_mc, m_flush_left;
    logic        m_red;
    logic [31:0] m_rpc;

    function automatic vec_t mkv(logic ifv, logic ifb, logic [31:0] ifpc, logic [31:0] iftg,
                                 logic exv, logic exb, logic exj, logic [31:0] expc, logic [31:0] extg,
                                 logic expt, logic exbr, logic ep, logic [31:0] eppc, logic er,
                                 logic [31:0] erpc, logic ef, logic [15:0] emc, logic [15:0] ebrc);
        vec_t v;
        v.ifv = ifv; v.ifb = ifb; v.ifpc = ifpc; v.iftg = iftg;
        v.exv = exv; v.exb = exb; v.exj = exj; v.expc = expc; v.extg = extg;
        v.expt = expt; v.exbr = exbr;
        v.e_pred = ep; v.e_ppc = eppc; v.e_red = er; v.e_rpc = erpc; v.e_flush = ef;
        v.e_mc = emc; v.e_brc = ebrc;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        bpi.if_valid = v.ifv;  bpi.if_is_branch = v.ifb; bpi.if_pc = v.ifpc; bpi.if_target = v.iftg;
        bpi.ex_valid = v.exv;  bpi.ex_is_branch = v.exb; bpi.ex_jump = v.exj;
        bpi.ex_pc = v.expc;    bpi.ex_target = v.extg;
        bpi.ex_pred_taken = v.expt; bpi.ex_branch = v.exbr;
    endtask

    task automatic idle_inputs();
        drive(mkv(0,0,0,0, 0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
    endtask

    task automatic do_reset();
        idle_inputs();
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_bht[i] = 1;
        m_brc = 0; m_mc = 0; m_flush_left = 0; m_red = 1'b0; m_rpc = 32'd0;
    endtask

    // one clock edge worth of architectural effect, from the rules rather than the FSM
    task automatic model_edge();
        int idx;
        logic taken;
        m_red = 1'b0;
        if (m_flush_left > 0) m_flush_left--;
        else if (bpi.ex_valid && bpi.ex_is_branch) begin
            idx   = (bpi.ex_pc >> 2) % 16;
            taken = bpi.ex_branch;
            m_brc = (m_brc + 1) % 65536;
            if (!bpi.ex_jump) m_bht[idx] = taken ? ((m_bht[idx] < 3) ? m_bht[idx] + 1 : 3)
                                                : ((m_bht[idx] > 0) ? m_bht[idx] - 1 : 0);
            if (taken != bpi.ex_pred_taken) begin
                m_red = 1'b1;
                m_rpc = taken ? bpi.ex_target : bpi.ex_pc + 32'd4;
                m_flush_left = FLUSH_CYC;
                m_mc = (m_mc + 1) % 65536;
            end
        end
    endtask

    initial begin
        vec_t v;
        logic        ep;
        logic [31:0] eppc;

        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        //        IF: v b pc target      EX: v b j pc target pt br   exp: pred ppc red rpc flush mc brc
        vt.push_back(mkv(0,0,32'h0,32'h0,     0,0,0,32'h0,32'h0,0,0,   0,32'h4,0,32'h0,0,0,0));
        vt.push_back(mkv(1,1,32'h40,32'h80,   1,1,0,32'h40,32'h80,0,1, 0,32'h44,0,32'h0,0,0,0));
        vt.push_back(mkv(1,1,32'h40,32'h80,   1,1,0,32'h40,32'h200,0,0,1,32'h80,1,32'h80,1,1,1));
        vt.push_back(mkv(1,1,32'h40,32'h80,   1,1,0,32'h40,32'h200,0,0,1,32'h80,0,32'h80,1,1,1));
        vt.push_back(mkv(1,1,32'h40,32'h80,   1,1,0,32'h40,32'h80,1,1, 1,32'h80,0,32'h80,0,1,1));
        vt.push_back(mkv(1,1,32'h40,32'h80,   1,1,0,32'h40,32'h80,1,1, 1,32'h80,0,32'h80,0,1,2));
        vt.push_back(mkv(1,1,32'h40,32'h80,   1,1,0,32'h40,32'h80,1,0, 1,32'h80,0,32'h80,0,1,3));
        vt.push_back(mkv(1,1,32'h40,32'h80,   0,0,0,32'h0,32'h0,0,0,   1,32'h80,1,32'h44,1,2,4));
        vt.push_back(mkv(0,0,32'h0,32'h0,     0,0,0,32'h0,32'h0,0,0,   0,32'h4,0,32'h44,1,2,4));
        vt.push_back(mkv(1,1,32'h10,32'h300,  1,1,1,32'h10,32'h100,0,1,0,32'h14,0,32'h44,0,2,4));
        vt.push_back(mkv(1,1,32'h10,32'h300,  0,0,0,32'h0,32'h0,0,0,   0,32'h14,1,32'h100,1,3,5));
        vt.push_back(mkv(1,1,32'h40,32'h80,   0,0,0,32'h0,32'h0,0,0,   1,32'h80,0,32'h100,1,3,5));
        vt.push_back(mkv(0,1,32'h40,32'h80,   0,0,0,32'h0,32'h0,0,0,   0,32'h44,0,32'h100,0,3,5));
        vt.push_back(mkv(1,0,32'hfffffffc,32'h8,0,0,0,32'h0,32'h0,0,0, 0,32'h0,0,32'h100,0,3,5));
        vt.push_back(mkv(0,0,32'h0,32'h0,     0,1,0,32'h40,32'h80,0,1, 0,32'h4,0,32'h100,0,3,5));
        vt.push_back(mkv(0,0,32'h0,32'h0,     1,0,0,32'h40,32'h80,0,1, 0,32'h4,0,32'h100,0,3,5));
        vt.push_back(mkv(0,0,32'h0,32'h0,     0,0,0,32'h0,32'h0,0,0,   0,32'h4,0,32'h100,0,3,5));

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i]);
            @(negedge clk);
            chk($sformatf("v%0d pred_taken", i),    {31'd0, bpi.pred_taken}, {31'd0, vt[i].e_pred});
            chk($sformatf("v%0d pred_pc", i),       bpi.pred_pc,             vt[i].e_ppc);
            chk($sformatf("v%0d redirect", i),      {31'd0, bpi.redirect},   {31'd0, vt[i].e_red});
            chk($sformatf("v%0d redirect_pc", i),   bpi.redirect_pc,         vt[i].e_rpc);
            chk($sformatf("v%0d flush", i),         {31'd0, bpi.flush},      {31'd0, vt[i].e_flush});
            chk($sformatf("v%0d mispred_count", i), {16'd0, bpi.mispred_count}, {16'd0, vt[i].e_mc});
            chk($sformatf("v%0d br_count", i),      {16'd0, bpi.br_count},   {16'd0, vt[i].e_brc});
            @(posedge clk);
            #1;
        end

        // reset asserted while flushing: flush drops without a clock edge, BHT returns to weakly not-taken
        drive(mkv(0,0,0,0, 1,1,0,32'h40,32'h80,0,1, 0,0,0,0,0,0,0));
        @(posedge clk);
        #1;
        idle_inputs();
        chk("midflush flush_pre", {31'd0, bpi.flush}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midflush flush_async", {31'd0, bpi.flush}, 32'd0);
        chk("midflush redirect",    {31'd0, bpi.redirect}, 32'd0);
        chk("midflush redirect_pc", bpi.redirect_pc, 32'd0);
        chk("midflush br_count",    {16'd0, bpi.br_count}, 32'd0);
        chk("midflush mispred",     {16'd0, bpi.mispred_count}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        drive(mkv(1,1,32'h40,32'h80, 0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
        #1;
        chk("postreset pred_taken", {31'd0, bpi.pred_taken}, 32'd0);
        chk("postreset pred_pc",    bpi.pred_pc, 32'h44);
        @(posedge clk);
        #1;

        // randomized traffic against the model
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            bpi.if_valid      = ($urandom_range(0, 9) != 0);
            bpi.if_is_branch  = ($urandom_range(0, 3) != 0);
            bpi.if_pc         = {$urandom_range(0, 63), 2'b00};
            bpi.if_target     = $urandom;
            bpi.ex_valid      = ($urandom_range(0, 4) != 0);
            bpi.ex_is_branch  = ($urandom_range(0, 2) != 0);
            bpi.ex_jump       = ($urandom_range(0, 7) == 0);
            bpi.ex_pc         = (c % 97 == 0) ? 32'hfffffffc : {$urandom_range(0, 63), 2'b00};
            bpi.ex_target     = $urandom;
            bpi.ex_branch     = bpi.ex_jump ? 1'b1 : $urandom_range(0, 1);
            bpi.ex_pred_taken = ($urandom_range(0, 3) == 0) ? ~bpi.ex_branch : bpi.ex_branch;
            @(negedge clk);
            ep   = bpi.if_valid && bpi.if_is_branch && (m_bht[(bpi.if_pc >> 2) % 16] >= 2);
            eppc = ep ? bpi.if_target : bpi.if_pc + 32'd4;
            chk("rnd pred_taken",    {31'd0, bpi.pred_taken}, {31'd0, ep});
            chk("rnd pred_pc",       bpi.pred_pc, eppc);
            chk("rnd redirect",      {31'd0, bpi.redirect}, {31'd0, m_red});
            chk("rnd redirect_pc",   bpi.redirect_pc, m_rpc);
            chk("rnd flush",         {31'd0, bpi.flush}, {31'd0, (m_flush_left > 0)});
            chk("rnd br_count",      {16'd0, bpi.br_count}, m_brc);
            chk("rnd mispred_count", {16'd0, bpi.mispred_count}, m_mc);
            @(posedge clk);
            model_edge();
            #1;
        end

        // statistics wrap: 2**16 correctly predicted resolves
        do_reset();
        drive(mkv(0,0,0,0, 1,1,0,32'h20,32'h60,1,1, 0,0,0,0,0,0,0));
        repeat (65535) @(posedge clk);
        #1;
        chk("wrap br_count_max", {16'd0, bpi.br_count}, 32'h0000ffff);
        chk("wrap flush_idle",   {31'd0, bpi.flush}, 32'd0);
        @(posedge clk);
        #1;
        idle_inputs();
        @(negedge clk);
        chk("wrap br_count_zero", {16'd0, bpi.br_count}, 32'd0);
        chk("wrap mispred_zero",  {16'd0, bpi.mispred_count}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
